// File: rtl/e_mdu_if.sv
// E-stage multiply/divide port bundle: issue side from the pipeline, HI/LO and busy back.
interface e_mdu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       mdOp;
    logic [WIDTH-1:0] srcA;
    logic [WIDTH-1:0] srcB;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, mdOp, srcA, srcB, input busy, hi, lo);
    modport slave  (input start, mdOp, srcA, srcB, output busy, hi, lo);
endinterface

// File: rtl/e_mdu.sv
// Multiply/divide unit with architectural HI/LO; mult/div results commit after a
// fixed latency while busy is held, mthi/mtlo write immediately.
module e_mdu #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic  clk,
    input  logic  reset,
    e_mdu_if.slave md
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    typedef enum logic [2:0] {
        MD_NOP   = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6,
        MD_RSVD  = 3'd7
    } md_op_e;

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    md_op_e           op_q, op_d, op_in;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

    logic [2*WIDTH-1:0] ext_a, ext_b, prod;
    logic [WIDTH-1:0]   mag_a, mag_b, q_u, r_u, quot, rem;
    logic               sgn, neg_q, neg_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= MD_NOP;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        op_in = md_op_e'(md.mdOp);

        // Signed forms are built from the unsigned core on magnitudes, which also
        // makes MIN / -1 wrap to MIN with a zero remainder without a special case.
        ext_a = (op_q == MD_MULT) ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
        ext_b = (op_q == MD_MULT) ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
        prod  = ext_a * ext_b;

        sgn   = (op_q == MD_DIV);
        mag_a = (sgn && a_q[WIDTH-1]) ? (~a_q + 1'b1) : a_q;
        mag_b = (sgn && b_q[WIDTH-1]) ? (~b_q + 1'b1) : b_q;
        q_u   = (mag_b != '0) ? (mag_a / mag_b) : '0;
        r_u   = (mag_b != '0) ? (mag_a % mag_b) : '0;
        neg_q = sgn && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        neg_r = sgn && a_q[WIDTH-1];
        quot  = neg_q ? (~q_u + 1'b1) : q_u;
        rem   = neg_r ? (~r_u + 1'b1) : r_u;

        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        unique case (state_q)
            S_IDLE: begin
                if (md.start) begin
                    unique case (op_in)
                        MD_MTHI: hi_d = md.srcA;
                        MD_MTLO: lo_d = md.srcA;
                        MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                            state_d = S_BUSY;
                            cnt_d   = ((op_in == MD_MULT) || (op_in == MD_MULTU))
                                      ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                            op_d    = op_in;
                            a_d     = md.srcA;
                            b_d     = md.srcB;
                        end
                        default: ;
                    endcase
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = S_IDLE;
                    if ((op_q == MD_MULT) || (op_q == MD_MULTU)) begin
                        hi_d = prod[2*WIDTH-1:WIDTH];
                        lo_d = prod[WIDTH-1:0];
                    end else if (b_q != '0) begin
                        hi_d = rem;
                        lo_d = quot;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign md.busy = (cnt_q != '0);
    assign md.hi   = hi_q;
    assign md.lo   = lo_q;
endmodule

// File: tb/tb_e_mdu.sv
// Scoreboard bench for e_mdu: expected HI/LO/busy-length pushed at issue, checked
// by a monitor each time busy falls; direct checks cover mthi/mtlo and reset.
module tb_e_mdu;
    logic clk = 1'b0;
    logic reset;

    e_mdu_if #(.WIDTH(32)) md ();

    e_mdu #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (md)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: a busy high->low transition is the DUT presenting a result.
    int   busy_run  = 0;
    logic busy_prev = 1'b0;
    always @(negedge clk) begin
        if (md.busy === 1'b1) begin
            busy_run++;
        end else begin
            if (busy_prev) begin
                if (sb.size() == 0) begin
                    check("unexpected_busy_fall", 64'(busy_run), 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check({e.name, "_busy_cycles"}, 64'(busy_run), 64'(e.cycles));
                    check({e.name, "_hi"}, 64'(md.hi), 64'(e.hi));
                    check({e.name, "_lo"}, 64'(md.lo), 64'(e.lo));
                end
            end
            busy_run = 0;
        end
        busy_prev = md.busy;
    end

    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        md.start = 1'b1;
        md.mdOp  = op;
        md.srcA  = a;
        md.srcB  = b;
        @(posedge clk); #1;
        md.start = 1'b0;
        md.mdOp  = 3'd0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                          input int cyc);
        sb.push_back('{name: name, hi: ehi, lo: elo, cycles: cyc});
        drive(op, a, b);
        md.srcA = 32'hDEAD_BEEF;
        md.srcB = 32'h0000_0003;
        idle(cyc + 2);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got sim time %0t expected completion", $time);
        $fatal(1, "timeout");
    end

    initial begin
        reset    = 1'b1;
        md.start = 1'b0;
        md.mdOp  = 3'd0;
        md.srcA  = '0;
        md.srcB  = '0;
        idle(2);
        reset = 1'b0;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_busy", 64'(md.busy), 64'd0);
            check("reset_hi", 64'(md.hi), 64'd0);
            check("reset_lo", 64'(md.lo), 64'd0);
        end
        @(posedge clk); #1;

        // mult with an mtlo attempted in its first busy cycle
        sb.push_back('{name: "mult", hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFFE, cycles: 5});
        drive(3'd1, 32'hFFFF_FFFF, 32'h0000_0002);
        drive(3'd6, 32'h0000_5555, 32'h0);
        check("mtlo_while_busy_lo", 64'(md.lo), 64'd0);
        idle(6);

        run_op("multu", 3'd2, 32'hFFFF_FFFF, 32'h2, 32'h0000_0001, 32'hFFFF_FFFE, 5);
        run_op("div_neg", 3'd3, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        run_op("divu", 3'd4, 32'h7, 32'h2, 32'h1, 32'h3, 10);
        run_op("div_min", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 10);

        drive(3'd5, 32'h0000_ABCD, 32'h0);
        check("mthi_busy", 64'(md.busy), 64'd0);
        drive(3'd6, 32'h0000_1234, 32'h0);
        check("mtlo_busy", 64'(md.busy), 64'd0);
        check("mthi_hi", 64'(md.hi), 64'h0000_ABCD);
        check("mtlo_lo", 64'(md.lo), 64'h0000_1234);

        drive(3'd5, 32'h11, 32'h0);
        drive(3'd6, 32'h22, 32'h0);
        drive(3'd7, 32'h99, 32'h99);
        drive(3'd0, 32'h99, 32'h99);
        check("nop_busy", 64'(md.busy), 64'd0);
        run_op("div_zero", 3'd3, 32'h5, 32'h0, 32'h11, 32'h22, 10);

        // abort: reset sampled on the edge ending the third busy cycle
        sb.push_back('{name: "abort", hi: 32'h0, lo: 32'h0, cycles: 3});
        drive(3'd1, 32'h3, 32'h4);
        idle(2);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        idle(10);
        check("post_abort_busy", 64'(md.busy), 64'd0);
        check("post_abort_hi", 64'(md.hi), 64'd0);
        check("post_abort_lo", 64'(md.lo), 64'd0);

        idle(2);
        check("pending_results", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
